axi_stream_header_arbiter: RTL and testbench

Round-robin scheduler that shares the single header-insert port of the AXI-Stream header-insertion datapath among NUM_SRC header requesters. It grants one requester, registers its header, and offers it on the valid_insert/ready_insert handshake. It then holds the grant until the inserter's output stream completes the packet (last_out handshake), so exactly one header is inserted per packet. It sits between the header sources and the inserter's insert port, and snoops the inserter's output handshake.

---
 rtl/axi_stream_header_arbiter_if.sv | 40 ++++
 rtl/axi_stream_header_arbiter.sv | 113 +++++++++++
 tb/tb_axi_stream_header_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_header_arbiter_if.sv
// Signal bundle between the header requesters, the header arbiter and the
// inserter's insert port and snooped output handshake.
interface axi_stream_header_arbiter_if #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned SRC_WD       = $clog2(NUM_SRC)
);
  logic [NUM_SRC-1:0]              req_valid;
  logic [NUM_SRC*DATA_WD-1:0]      req_data;
  logic [NUM_SRC*DATA_BYTE_WD-1:0] req_keep;
  logic [NUM_SRC-1:0]              req_ready;
  logic                            valid_insert;
  logic [DATA_WD-1:0]              data_insert;
  logic [DATA_BYTE_WD-1:0]         keep_insert;
  logic [BYTE_CNT_WD:0]            byte_insert_cnt;
  logic                            ready_insert;
  logic                            valid_out;
  logic                            ready_out;
  logic                            last_out;
  logic [SRC_WD-1:0]               grant_id;
  logic                            busy;
  logic                            hdr_drop;
  logic [15:0]                     pkt_cnt;

  // Arbiter side
  modport master (
    input  req_valid, req_data, req_keep, ready_insert, valid_out, ready_out, last_out,
    output req_ready, valid_insert, data_insert, keep_insert, byte_insert_cnt,
           grant_id, busy, hdr_drop, pkt_cnt
  );

  // Requester / inserter side
  modport slave (
    output req_valid, req_data, req_keep, ready_insert, valid_out, ready_out, last_out,
    input  req_ready, valid_insert, data_insert, keep_insert, byte_insert_cnt,
           grant_id, busy, hdr_drop, pkt_cnt
  );
endinterface

// File: rtl/axi_stream_header_arbiter.sv
// Round-robin arbiter sharing the header-insert port among NUM_SRC requesters;
// holds each grant until the inserter's output completes the packet.
module axi_stream_header_arbiter #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
  parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned SRC_WD       = $clog2(NUM_SRC)
) (
  input logic clk,
  input logic rst,
  axi_stream_header_arbiter_if.master bus
);
  localparam int unsigned CNT_WD = BYTE_CNT_WD + 1;

  typedef enum logic [1:0] {IDLE, OFFER, WAIT_EOP} state_t;

  state_t                  state, state_nxt;
  logic [SRC_WD-1:0]       last_grant;
  logic [SRC_WD-1:0]       cand;
  logic [SRC_WD-1:0]       win_idx;
  logic                    win_found;
  logic [DATA_WD-1:0]      win_data;
  logic [DATA_BYTE_WD-1:0] win_keep;
  logic [CNT_WD-1:0]       win_cnt;
  logic                    hdr_hs;
  logic                    eop_hs;

  assign hdr_hs = bus.valid_insert & bus.ready_insert;
  assign eop_hs = bus.valid_out & bus.ready_out & bus.last_out;

  // Round-robin search starting just after the last granted source
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      cand = SRC_WD'((32'(last_grant) + i) % NUM_SRC);
      if (!win_found && bus.req_valid[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // Winner payload mux and keep popcount
  always_comb begin
    win_data = '0;
    win_keep = '0;
    win_cnt  = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (SRC_WD'(s) == win_idx) begin
        win_data = bus.req_data[s*DATA_WD +: DATA_WD];
        win_keep = bus.req_keep[s*DATA_BYTE_WD +: DATA_BYTE_WD];
      end
    end
    for (int unsigned b = 0; b < DATA_BYTE_WD; b++) begin
      win_cnt = win_cnt + CNT_WD'(win_keep[b]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and the combinational accept pulse to the winner
  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (win_found && !rst) begin
          bus.req_ready[win_idx] = 1'b1;
          state_nxt = (win_keep != '0) ? OFFER : IDLE;
        end
      end
      OFFER:    if (hdr_hs) state_nxt = WAIT_EOP;
      WAIT_EOP: if (eop_hs) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Registered header, status and packet counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant          <= SRC_WD'(NUM_SRC - 1);
      bus.valid_insert    <= 1'b0;
      bus.data_insert     <= '0;
      bus.keep_insert     <= '0;
      bus.byte_insert_cnt <= '0;
      bus.grant_id        <= '0;
      bus.busy            <= 1'b0;
      bus.hdr_drop        <= 1'b0;
      bus.pkt_cnt         <= '0;
    end else begin
      bus.valid_insert <= (state_nxt == OFFER);
      bus.busy         <= (state_nxt != IDLE);
      bus.hdr_drop     <= 1'b0;
      if (state == IDLE && win_found) begin
        bus.data_insert     <= win_data;
        bus.keep_insert     <= win_keep;
        bus.byte_insert_cnt <= win_cnt;
        bus.grant_id        <= win_idx;
        last_grant          <= win_idx;
        bus.hdr_drop        <= (win_keep == '0);
      end
      if (state == WAIT_EOP && eop_hs && bus.pkt_cnt != 16'hFFFF) begin
        bus.pkt_cnt <= bus.pkt_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Scoreboard bench for axi_stream_header_arbiter: a round-robin model predicts
// each grant and header; inserted headers are compared as they are accepted.
module tb_axi_stream_header_arbiter;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic [2:0]  cnt;
    logic [1:0]  id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_data [4];
  logic [3:0]  src_keep [4];
  exp_t        sb [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          npush  = 0;
  int          npop   = 0;
  int          mdl_last;
  int          mdl_pkt;
  int          exp_order [5] = '{0, 1, 2, 3, 0};

  axi_stream_header_arbiter_if #(.DATA_WD(32), .NUM_SRC(4)) bus ();

  axi_stream_header_arbiter #(.DATA_WD(32), .NUM_SRC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.req_data = {src_data[3], src_data[2], src_data[1], src_data[0]};
  assign bus.req_keep = {src_keep[3], src_keep[2], src_keep[1], src_keep[0]};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int mdl_winner(input logic [3:0] v);
    for (int i = 1; i <= 4; i++) begin
      if (v[(mdl_last + i) % 4]) return (mdl_last + i) % 4;
    end
    return 0;
  endfunction

  task automatic check_reset_vals(input string p);
    check({p, "_valid"},   64'(bus.valid_insert),    64'(0));
    check({p, "_data"},    64'(bus.data_insert),     64'(0));
    check({p, "_keep"},    64'(bus.keep_insert),     64'(0));
    check({p, "_cnt"},     64'(bus.byte_insert_cnt), 64'(0));
    check({p, "_rr"},      64'(bus.req_ready),       64'(0));
    check({p, "_gid"},     64'(bus.grant_id),        64'(0));
    check({p, "_busy"},    64'(bus.busy),            64'(0));
    check({p, "_drop"},    64'(bus.hdr_drop),        64'(0));
    check({p, "_pktcnt"},  64'(bus.pkt_cnt),         64'(0));
  endtask

  task automatic clear_out();
    bus.valid_out = 1'b0;
    bus.ready_out = 1'b0;
    bus.last_out  = 1'b0;
  endtask

  // One arbitration + packet, entered at posedge+1 of an IDLE cycle
  task automatic run_pkt(input logic [3:0] vld, input int bp, input int eop_gap,
                         input bit spurious);
    int         w;
    logic [3:0] exp_rr;
    exp_t       e;
    w      = mdl_winner(vld);
    exp_rr = 4'b0001 << w;
    bus.req_valid    = vld;
    bus.ready_insert = (bp == 0);
    @(negedge clk);
    check("req_ready", 64'(bus.req_ready), 64'(exp_rr));
    mdl_last = w;
    e.d   = src_data[w];
    e.k   = src_keep[w];
    e.cnt = 3'($countones(src_keep[w]));
    e.id  = 2'(w);
    @(posedge clk); #1;
    bus.req_valid = '0;
    if (e.k == 4'b0000) begin
      @(negedge clk);
      check("drop_pulse", 64'(bus.hdr_drop),     64'(1));
      check("drop_valid", 64'(bus.valid_insert), 64'(0));
      check("drop_busy",  64'(bus.busy),         64'(0));
      check("drop_gid",   64'(bus.grant_id),     64'(w));
      @(posedge clk); #1;
      @(negedge clk);
      check("drop_end",    64'(bus.hdr_drop),     64'(0));
      check("drop_valid2", 64'(bus.valid_insert), 64'(0));
      @(posedge clk); #1;
      return;
    end
    sb.push_back(e);
    npush++;
    if (spurious) begin
      bus.valid_out = 1'b1; bus.ready_out = 1'b1; bus.last_out = 1'b1;
    end
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.valid_insert), 64'(1));
      check("bp_data",  64'(bus.data_insert),  64'(e.d));
      check("bp_keep",  64'(bus.keep_insert),  64'(e.k));
      check("bp_rr",    64'(bus.req_ready),    64'(0));
      @(posedge clk); #1;
      clear_out();
    end
    bus.ready_insert = 1'b1;
    @(negedge clk);
    check("offer_valid",  64'(bus.valid_insert), 64'(1));
    check("offer_busy",   64'(bus.busy),         64'(1));
    check("offer_gid",    64'(bus.grant_id),     64'(w));
    check("offer_pktcnt", 64'(bus.pkt_cnt),      64'(mdl_pkt));
    @(posedge clk); #1;
    clear_out();
    if (spurious) begin
      bus.valid_out = 1'b1; bus.ready_out = 1'b0; bus.last_out = 1'b1;
    end
    for (int c = 1; c < eop_gap; c++) begin
      @(negedge clk);
      check("wait_valid",  64'(bus.valid_insert), 64'(0));
      check("wait_busy",   64'(bus.busy),         64'(1));
      check("wait_pktcnt", 64'(bus.pkt_cnt),      64'(mdl_pkt));
      @(posedge clk); #1;
      clear_out();
    end
    bus.valid_out = 1'b1; bus.ready_out = 1'b1; bus.last_out = 1'b1;
    @(posedge clk); #1;
    clear_out();
    if (mdl_pkt < 65535) mdl_pkt++;
    @(negedge clk);
    check("eop_pktcnt", 64'(bus.pkt_cnt), 64'(mdl_pkt));
    check("eop_busy",   64'(bus.busy),    64'(0));
    @(posedge clk); #1;
  endtask

  // Scoreboard: compare every accepted header against the predicted one
  always @(negedge clk) begin
    if (!rst && bus.valid_insert && bus.ready_insert) begin
      npop++;
      if (sb.size() == 0) begin
        check("sb_unexpected", 64'(1), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        check("ins_data", 64'(bus.data_insert),     64'(mon_e.d));
        check("ins_keep", 64'(bus.keep_insert),     64'(mon_e.k));
        check("ins_cnt",  64'(bus.byte_insert_cnt), 64'(mon_e.cnt));
        check("ins_gid",  64'(bus.grant_id),        64'(mon_e.id));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   w;
    exp_t e;
    rst = 1'b1;
    bus.req_valid    = '0;
    bus.ready_insert = 1'b0;
    clear_out();
    for (int i = 0; i < 4; i++) begin
      src_data[i] = 32'hC0DE_0000 | 32'(i);
      src_keep[i] = 4'hF;
    end
    mdl_last = 3;
    mdl_pkt  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single source, partial keep
    src_data[0] = 32'hA5A5_0001;
    src_keep[0] = 4'b0111;
    run_pkt(4'b0001, 0, 3, 1'b0);
    src_data[0] = 32'hC0DE_0000;
    src_keep[0] = 4'hF;

    repeat (4) run_pkt(4'b1111, 0, 3, 1'b0);

    // Reset in WAIT_EOP with five packets completed
    bus.req_valid    = 4'b0010;
    bus.ready_insert = 1'b1;
    w = mdl_winner(4'b0010);
    @(negedge clk);
    check("pre_rst_rr", 64'(bus.req_ready), 64'(4'b0010));
    e.d = src_data[w]; e.k = src_keep[w];
    e.cnt = 3'($countones(src_keep[w])); e.id = 2'(w);
    sb.push_back(e);
    npush++;
    mdl_last = w;
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_busy",   64'(bus.busy),    64'(1));
    check("pre_rst_pktcnt", 64'(bus.pkt_cnt), 64'(5));
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    mdl_last = 3;
    mdl_pkt  = 0;

    // All sources requesting: rotation from source 0
    for (int j = 0; j < 5; j++) begin
      run_pkt(4'b1111, 0, 3, 1'b0);
      check("rr_order", 64'(bus.grant_id), 64'(exp_order[j]));
    end

    // Backpressure plus spurious last beats in OFFER and WAIT_EOP
    run_pkt(4'b1111, 5, 3, 1'b1);

    // Zero keep from source 2, then source 3 wins
    run_pkt(4'b1000, 0, 2, 1'b0);
    src_keep[2] = 4'b0000;
    run_pkt(4'b1100, 0, 2, 1'b0);
    run_pkt(4'b1100, 0, 2, 1'b0);
    check("after_drop_gid", 64'(bus.grant_id), 64'(3));
    src_keep[2] = 4'hF;

    check("sb_left",   64'(sb.size()), 64'(0));
    check("ins_total", 64'(npop),      64'(npush));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
